elevator_scheduler: RTL
=======================

# elevator_scheduler

Collective-control scheduler for the three-floor car position register. It latches hall/car calls per floor and decides travel direction with a sweep (SCAN) policy. It issues single-cycle `up`/`down` step commands to the position register and times door-open dwell at each served floor. It sits between the call buttons and the position register, reading the current floor back as feedback.

## Interface

- `TRAVEL_CYCLES`, default 3: cycles from one step command to the next arrival decision; legal range ≥2.
- `DOOR_CYCLES`, default 4: cycles `door_open` stays high per stop; legal range ≥1.

- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `call` in 3: bit i = request for floor i+1; level or pulse, sampled every cycle.
- `floor` in 2: current floor from position register; 1, 2, 3 valid, 0 invalid.
- `up` out 1: one-cycle step-up command to position register.
- `down` out 1: one-cycle step-down command to position register.
- `door_open` out 1: door open at current floor.
- `pending` out 3: latched outstanding requests, bit i = floor i+1.
- `dir_up` out 1: current/last sweep direction, 1 = up.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation

- Reset values: state IDLE, `pending`=0, `up`=`down`=`door_open`=`busy`=0, `dir_up`=1, counters 0. Reset overrides all, including mid-travel and mid-door; `call` is ignored while reset is high.
- Request latch: `pending[i]` is set on any cycle with `call[i]`=1. It is cleared on entry to DOOR at floor i+1.
  - Exception: `call` for the current floor while in DOOR does not set `pending`. It reloads the door counter to DOOR_CYCLES instead.
- "Ahead" means pending floors above current if `dir_up`=1, below if 0. "Behind" is the opposite.
- Decision rule, applied in IDLE, at arrival (last TRAVEL cycle) and at door close (last DOOR cycle):
  - `pending` at current floor: go to DOOR. This does not apply at door close, where that bit was just cleared.
  - Otherwise, any pending ahead: go to STEP in `dir_up` direction.
  - Otherwise, any pending behind: toggle `dir_up`, then go to STEP.
  - Otherwise: go to IDLE.
- States:
  - IDLE: apply the decision rule to registered `pending` each cycle.
  - STEP (1 cycle): `up`=1 if `dir_up`, else `down`=1. Next state is TRAVEL.
  - TRAVEL (TRAVEL_CYCLES−1 cycles): no command asserted. On the last cycle, apply the decision rule using the updated `floor`.
  - DOOR (DOOR_CYCLES cycles, reloadable): `door_open`=1.
- Intermediate stops: a call for a floor being passed that latches before the arrival decision causes a stop there.
- Safety invariants:
  - `up` and `down` are never both high.
  - `up` is never asserted while `floor`=3; `down` is never asserted while `floor`=1.
  - `door_open` is never high in the same cycle as `up` or `down`.
- Invalid `floor` (0): remain in IDLE with no commands and no door; pending requests are still latched. Scheduling resumes when `floor` is valid.

## Timing

- `call` high in cycle c → `pending` bit visible in c+1 → IDLE decides in c+1 → first command or `door_open` in c+2.
- The position register updates on the edge after a STEP cycle. Consecutive step commands are exactly TRAVEL_CYCLES cycles apart.
- Arrival at a requested floor: `door_open` rises in the cycle after the last TRAVEL cycle. It stays high exactly DOOR_CYCLES cycles unless a current-floor call reloads the counter.
- Door close to next STEP: 0 idle cycles. The decision is made in the last DOOR cycle.

## Test plan

- Reset: hold `reset` 2 cycles with `call`=3'b111 → all outputs 0, `dir_up`=1, `pending`=0 after release.
- Floor 1, `call`=3'b100 for 1 cycle at c → `up` pulses at c+2 and c+5; `floor` reaches 3; `door_open` high c+8..c+11; `pending`=0; `busy` low from c+12.
- Floor 3 idle, `call`=3'b011 in one cycle → one `down` pulse, stop at 2 with 4 door cycles, then one `down` pulse, stop at 1; `dir_up`=0 throughout.
- Floor 1 moving up to 3, `call[0]` pulsed at the first TRAVEL cycle → continues to 3, door, then `dir_up`→0, two `down` pulses, door at 1.
- In DOOR at floor 2, `call[1]` pulsed on the 3rd door cycle → `door_open` lasts 2+4=6 cycles total; `pending[1]` stays 0.
- `reset` asserted during TRAVEL with `pending`=3'b100 → next cycle `up`/`down`/`door_open`=0, `pending`=0, state IDLE, no further commands.

Source files
------------

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN collective-control scheduler issuing step commands and door dwell for a three-floor car.
module elevator_scheduler #(
  parameter int TRAVEL_CYCLES = 3,
  parameter int DOOR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] call,
  input  logic [1:0] floor,
  output logic       up,
  output logic       down,
  output logic       door_open,
  output logic [2:0] pending,
  output logic       dir_up,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, STEP, TRAVEL, DOOR} state_t;
  localparam int MAXC = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, eff;
  logic [2:0] pending_n, here_m, below_m, above_m;
  logic dir_n, valid, reload, decide, go_door, ahead, behind;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pending <= '0;
      dir_up <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pending <= pending_n;
      dir_up <= dir_n;
    end
  // a current-floor call during DOOR restarts the dwell counting this cycle as its first
  always_comb begin
    valid = floor != 2'd0;
    here_m = valid ? 3'b001 << (floor - 2'd1) : 3'b000;
    below_m = here_m - 3'd1;
    above_m = ~(here_m | below_m);
    reload = state == DOOR && |(call & here_m);
    eff = reload ? CW'(DOOR_CYCLES - 1) : cnt;
    decide = state == IDLE || (state == TRAVEL && cnt == '0) || (state == DOOR && eff == '0);
    go_door = state != DOOR && |(pending & here_m);
    ahead = |(pending & (dir_up ? above_m : below_m));
    behind = |(pending & (dir_up ? below_m : above_m));
    state_n = !decide ? (state == STEP ? TRAVEL : state) :
              !valid ? IDLE : go_door ? DOOR : (ahead | behind) ? STEP : IDLE;
    dir_n = decide && valid && !go_door && !ahead && behind ? ~dir_up : dir_up;
    cnt_n = state == STEP ? CW'(TRAVEL_CYCLES - 2) :
            state != DOOR && state_n == DOOR ? CW'(DOOR_CYCLES - 1) :
            (state == TRAVEL || state == DOOR) && !decide ? eff - 1'b1 : '0;
    pending_n = (pending | (call & ~(state == DOOR ? here_m : 3'b000))) &
                ~(decide && valid && go_door ? here_m : 3'b000);
  end
  always_comb begin
    up = state == STEP && dir_up && floor != 2'd3;
    down = state == STEP && !dir_up && floor != 2'd1;
    door_open = state == DOOR;
    busy = state != IDLE;
  end
endmodule
